// File: rtl/checkout_controller.sv
// checkout_controller
//   Scan-station sequencer. A rising edge on scan (seen in IDLE) captures the
//   item code and security mark, evaluates them for one cycle, then either
//   counts the item and holds the result, or raises a blinking alarm until
//   the operator acknowledges it.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   scan          scan request level; a request is its 0->1 transition
//   upc[2:0]      item code, registered with scan
//   marked        item security mark, registered with scan
//   ack           operator acknowledge, only honoured in ALARM
//   total[3:0]    accepted non-stolen items, saturates at 9
//   disc_count    accepted discounted non-stolen items, saturates at 9
//   last_upc      code of the most recently evaluated item
//   last_valid    an item has been evaluated since reset
//   discount_led  most recent item was discounted
//   stolen_led    most recent item was flagged stolen
//   alarm         blinking alarm drive (registered)
//   busy          controller is not IDLE (registered)
//
// state | meaning
// IDLE  | waiting for a scan rising edge
// EVAL  | one cycle: publish item result, update counts
// HOLD  | result held for HOLD_CYCLES cycles, scans dropped
// ALARM | stolen item, alarm blinking until ack

module checkout_controller #(
   parameter int HOLD_CYCLES  = 8,
   parameter int BLINK_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scan,
   input  logic [2:0] upc,
   input  logic       marked,
   input  logic       ack,
   output logic [3:0] total,
   output logic [3:0] disc_count,
   output logic [2:0] last_upc,
   output logic       last_valid,
   output logic       discount_led,
   output logic       stolen_led,
   output logic       alarm,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] BLINK_LOAD = 8'(BLINK_CYCLES - 1);
   localparam logic [3:0] COUNT_MAX  = 4'd9;

   state_t     r_state, w_next;
   logic       r_scan_s, r_scan_q, r_first;
   logic [2:0] r_upc_s, r_cap_upc, w_cap_upc;
   logic       r_marked_s, r_cap_marked, w_cap_marked;
   logic [7:0] r_hold, w_hold;
   logic [7:0] r_blink, w_blink;
   logic [3:0] r_total, w_total;
   logic [3:0] r_disc, w_disc;
   logic [2:0] r_last_upc, w_last_upc;
   logic       r_last_valid, w_last_valid;
   logic       r_disc_led, w_disc_led;
   logic       r_stolen_led, w_stolen_led;
   logic       r_alarm, w_alarm;
   logic       r_busy;
   logic       w_req;
   logic       w_is_disc, w_is_stolen;

   // scan/upc/marked are registered first, so a scan sampled high at edge N
   // is recognised at edge N+1 and its result appears at edge N+2.
   assign w_req       = r_scan_s & ~r_scan_q;
   assign w_is_disc   = r_cap_upc[2] | (r_cap_upc[1] & r_cap_upc[0]);
   assign w_is_stolen = ~r_cap_marked & ~r_cap_upc[0] & ~(r_cap_upc[2] & r_cap_upc[1]);

   always_comb begin
      w_next       = r_state;
      w_cap_upc    = r_cap_upc;
      w_cap_marked = r_cap_marked;
      w_hold       = r_hold;
      w_blink      = r_blink;
      w_total      = r_total;
      w_disc       = r_disc;
      w_last_upc   = r_last_upc;
      w_last_valid = r_last_valid;
      w_disc_led   = r_disc_led;
      w_stolen_led = r_stolen_led;
      w_alarm      = r_alarm;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_cap_upc    = r_upc_s;
               w_cap_marked = r_marked_s;
               w_next       = ST_EVAL;
            end
         end
         ST_EVAL: begin
            w_last_upc   = r_cap_upc;
            w_last_valid = 1'b1;
            w_disc_led   = w_is_disc;
            w_stolen_led = w_is_stolen;
            if (w_is_stolen) begin
               w_blink = BLINK_LOAD;
               w_alarm = 1'b1;
               w_next  = ST_ALARM;
            end else begin
               if (r_total < COUNT_MAX) w_total = r_total + 4'd1;
               if (w_is_disc && (r_disc < COUNT_MAX)) w_disc = r_disc + 4'd1;
               w_hold = HOLD_LOAD;
               w_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (r_hold == 8'd0) w_next = ST_IDLE;
            else                w_hold = r_hold - 8'd1;
         end
         ST_ALARM: begin
            if (ack) begin
               w_alarm      = 1'b0;
               w_stolen_led = 1'b0;
               w_blink      = 8'd0;
               w_next       = ST_IDLE;
            end else if (r_blink == 8'd0) begin
               w_alarm = ~r_alarm;
               w_blink = BLINK_LOAD;
            end else begin
               w_blink = r_blink - 8'd1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_scan_s     <= 1'b0;
         r_scan_q     <= 1'b0;
         r_first      <= 1'b1;
         r_upc_s      <= 3'd0;
         r_marked_s   <= 1'b0;
         r_cap_upc    <= 3'd0;
         r_cap_marked <= 1'b0;
         r_hold       <= 8'd0;
         r_blink      <= 8'd0;
         r_total      <= 4'd0;
         r_disc       <= 4'd0;
         r_last_upc   <= 3'd0;
         r_last_valid <= 1'b0;
         r_disc_led   <= 1'b0;
         r_stolen_led <= 1'b0;
         r_alarm      <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_scan_s     <= scan;
         // On the first edge after reset the previous-sample register copies
         // scan itself, so a scan already high at release is not an edge.
         r_scan_q     <= r_first ? scan : r_scan_s;
         r_first      <= 1'b0;
         r_upc_s      <= upc;
         r_marked_s   <= marked;
         r_cap_upc    <= w_cap_upc;
         r_cap_marked <= w_cap_marked;
         r_hold       <= w_hold;
         r_blink      <= w_blink;
         r_total      <= w_total;
         r_disc       <= w_disc;
         r_last_upc   <= w_last_upc;
         r_last_valid <= w_last_valid;
         r_disc_led   <= w_disc_led;
         r_stolen_led <= w_stolen_led;
         r_alarm      <= w_alarm;
         r_busy       <= (w_next != ST_IDLE);
      end
   end

   assign total        = r_total;
   assign disc_count   = r_disc;
   assign last_upc     = r_last_upc;
   assign last_valid   = r_last_valid;
   assign discount_led = r_disc_led;
   assign stolen_led   = r_stolen_led;
   assign alarm        = r_alarm;
   assign busy         = r_busy;

endmodule

// File: tb/tb_checkout_controller.sv
module tb_checkout_controller;

   localparam int H = 8;
   localparam int B = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       scan = 1'b0;
   logic [2:0] upc = 3'd0;
   logic       marked = 1'b0;
   logic       ack = 1'b0;
   logic [3:0] total, disc_count;
   logic [2:0] last_upc;
   logic       last_valid, discount_led, stolen_led, alarm, busy;

   checkout_controller #(.HOLD_CYCLES(H), .BLINK_CYCLES(B)) dut (
      .clk(clk), .reset_n(reset_n), .scan(scan), .upc(upc), .marked(marked), .ack(ack),
      .total(total), .disc_count(disc_count), .last_upc(last_upc), .last_valid(last_valid),
      .discount_led(discount_led), .stolen_led(stolen_led), .alarm(alarm), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic f_disc(input logic [2:0] u);
      return u[2] | (u[1] & u[0]);
   endfunction
   function automatic logic f_stolen(input logic [2:0] u, input logic m);
      return ~m & ~u[0] & ~(u[2] & u[1]);
   endfunction

   // Reference model: phase plus timestamps; blink level derived arithmetically
   // from the edge count since the alarm started.
   int         m_phase;   // 0 idle, 1 eval, 2 hold, 3 alarm
   int         m_k, m_idle_at, m_alarm_start;
   logic       m_s1, m_s0, m_first;
   logic [2:0] m_upc_s, m_cap_upc, m_last;
   logic       m_mark_s, m_cap_mark;
   logic [3:0] m_total, m_disc;
   logic       m_valid, m_dled, m_sled, m_alarm;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0; m_k = 0; m_idle_at = 0; m_alarm_start = 0;
         m_s1 = 0; m_s0 = 0; m_first = 1;
         m_upc_s = 0; m_cap_upc = 0; m_last = 0; m_mark_s = 0; m_cap_mark = 0;
         m_total = 0; m_disc = 0; m_valid = 0; m_dled = 0; m_sled = 0; m_alarm = 0;
      end else begin
         m_k++;
         case (m_phase)
            0: if (m_s1 && !m_s0) begin
                  m_cap_upc = m_upc_s; m_cap_mark = m_mark_s; m_phase = 1;
               end
            1: begin
                  m_last = m_cap_upc; m_valid = 1;
                  m_dled = f_disc(m_cap_upc);
                  m_sled = f_stolen(m_cap_upc, m_cap_mark);
                  if (m_sled) begin
                     m_phase = 3; m_alarm_start = m_k;
                  end else begin
                     if (m_total < 9) m_total = m_total + 1;
                     if (m_dled && m_disc < 9) m_disc = m_disc + 1;
                     m_idle_at = m_k + H; m_phase = 2;
                  end
               end
            2: if (m_k == m_idle_at) m_phase = 0;
            default: if (ack) begin m_phase = 0; m_sled = 0; end
         endcase
         m_alarm = (m_phase == 3) ? (((m_k - m_alarm_start) / B) % 2 == 0) : 1'b0;
         m_s0 = m_first ? scan : m_s1;
         m_s1 = scan; m_upc_s = upc; m_mark_s = marked; m_first = 0;
      end
   end

   logic [15:0] dut_vec, mdl_vec;
   assign dut_vec = {total, disc_count, last_upc, last_valid, discount_led, stolen_led, alarm, busy};
   assign mdl_vec = {m_total, m_disc, m_last, m_valid, m_dled, m_sled, m_alarm, logic'(m_phase != 0)};

   always @(negedge clk) check("cycle_vs_model", dut_vec, mdl_vec);

   typedef struct {
      logic [2:0] upc;
      logic       marked;
      logic [3:0] exp_total;
      logic [3:0] exp_disc;
      logic       exp_dled;
      logic       exp_sled;
   } vec_t;

   vec_t tbl[7];

   task automatic pulse(input logic [2:0] u, input logic m);
      scan = 1'b1; upc = u; marked = m;
      @(negedge clk);
      scan = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      n_total++; n_bad++;
      $display("FAIL wait_idle: busy still %b after 60 cycles, required 0", busy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check("async_reset", dut_vec, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{3'b101, 1'b1, 4'd1, 4'd1, 1'b1, 1'b0};
      tbl[1] = '{3'b010, 1'b1, 4'd2, 4'd1, 1'b0, 1'b0};
      tbl[2] = '{3'b000, 1'b0, 4'd2, 4'd1, 1'b0, 1'b1};
      tbl[3] = '{3'b110, 1'b0, 4'd3, 4'd2, 1'b1, 1'b0};
      tbl[4] = '{3'b011, 1'b1, 4'd4, 4'd3, 1'b1, 1'b0};
      tbl[5] = '{3'b100, 1'b0, 4'd4, 4'd3, 1'b1, 1'b1};
      tbl[6] = '{3'b001, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0};

      #3 check("reset_state", dut_vec, 16'h0000);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         int busy_cyc;
         busy_cyc = 0;
         pulse(tbl[i].upc, tbl[i].marked);
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
               check("tbl_total", 16'(total), 16'(tbl[i].exp_total));
               check("tbl_disc",  16'(disc_count), 16'(tbl[i].exp_disc));
               check("tbl_leds",  {13'd0, last_upc}, {13'd0, tbl[i].upc});
               check("tbl_flags", {12'd0, last_valid, discount_led, stolen_led, alarm},
                     {12'd0, 1'b1, tbl[i].exp_dled, tbl[i].exp_sled, tbl[i].exp_sled});
            end
            if (tbl[i].exp_sled) begin
               if (c == 5) check("blink_off", 16'(alarm), 16'd0);
               if (c == 9) begin
                  check("blink_on", 16'(alarm), 16'd1);
                  break;
               end
            end else begin
               if (busy) busy_cyc++;
               else if (c > 0) break;
            end
         end
         if (tbl[i].exp_sled) begin
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            check("ack_clear", {13'd0, stolen_led, alarm, busy}, 16'd0);
         end else begin
            check("busy_len", 16'(busy_cyc), 16'(1 + H));
         end
      end

      // ack ignored in IDLE and during HOLD
      ack = 1'b1; @(negedge clk); ack = 1'b0;
      check("ack_idle", {8'd0, total, 3'd0, busy}, {8'd0, 4'd5, 3'd0, 1'b0});
      pulse(3'b010, 1'b1);
      repeat (4) @(negedge clk);
      ack = 1'b1; @(negedge clk); ack = 1'b0;
      check("ack_hold_busy", 16'(busy), 16'd1);
      wait_idle();
      check("ack_hold_total", 16'(total), 16'd6);

      // saturation
      do_reset();
      for (int i = 0; i < 12; i++) begin
         pulse(3'b011, 1'b1);
         wait_idle();
      end
      check("sat_total", 16'(total), 16'd9);
      check("sat_disc",  16'(disc_count), 16'd9);

      // drops: second pulse in HOLD, scan held high into IDLE, then clean pulse
      do_reset();
      pulse(3'b010, 1'b1);
      repeat (3) @(negedge clk);
      pulse(3'b101, 1'b1);
      repeat (2) @(negedge clk);
      scan = 1'b1;
      repeat (20) @(negedge clk);
      check("held_idle", {8'd0, total, 3'd0, busy}, {8'd0, 4'd1, 3'd0, 1'b0});
      scan = 1'b0;
      @(negedge clk);
      pulse(3'b101, 1'b1);
      wait_idle();
      check("drop_total", 16'(total), 16'd2);
      check("drop_disc",  16'(disc_count), 16'd1);

      // reset in HOLD, then in ALARM
      pulse(3'b110, 1'b0);
      repeat (4) @(negedge clk);
      do_reset();
      pulse(3'b000, 1'b0);
      repeat (5) @(negedge clk);
      check("alarm_before_reset", {14'd0, stolen_led, busy}, 16'd3);
      do_reset();
      pulse(3'b101, 1'b1);
      wait_idle();
      check("after_reset_total", 16'(total), 16'd1);

      // scan already high at reset release is not a request
      @(negedge clk); #2 reset_n = 1'b0;
      scan = 1'b1;
      @(negedge clk); reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("scan_high_release", {8'd0, total, 3'd0, busy}, 16'd0);
      scan = 1'b0;
      @(negedge clk);

      // randomized traffic against the model
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 2) == 0) scan = ~scan;
         upc    = 3'($urandom_range(0, 7));
         marked = 1'($urandom_range(0, 1));
         ack    = ($urandom_range(0, 9) == 0);
      end
      ack = 1'b0; scan = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
